// File: rtl/regfile_wb_scheduler_pkg.sv
// regfile_wb_scheduler_pkg: shared types and constants for the writeback scheduler slice
package regfile_wb_scheduler_pkg;
    localparam int NREG = 32;
    typedef logic [4:0] creg_addr_t;
    typedef struct packed {
        logic       valid;
        creg_addr_t rd;
        logic [63:0] data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// regfile_wb_scheduler_if: writeback request bus from the execute/mem units to the scheduler
interface regfile_wb_scheduler_if #(parameter int N_REQ = 2, parameter int XLEN = 64);
    logic [N_REQ-1:0]      wb_valid;
    logic [N_REQ*5-1:0]    wb_rd;
    logic [N_REQ*XLEN-1:0] wb_data;
    logic [N_REQ-1:0]      wb_ready;
    modport master (output wb_valid, wb_rd, wb_data, input wb_ready);
    modport slave (input wb_valid, wb_rd, wb_data, output wb_ready);
endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, search starting at an internally held pointer
module rr_arbiter #(parameter int N = 2) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PW = N > 1 ? $clog2(N) : 1;
    logic [PW-1:0] rrPtr, ptrNext;
    logic found;
    // first requester at or after rrPtr wins; pointer moves just past the winner
    always_comb begin
        gnt = '0;
        found = 1'b0;
        ptrNext = rrPtr;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(rrPtr) + k) % N]) begin
                gnt[(int'(rrPtr) + k) % N] = 1'b1;
                found = 1'b1;
                ptrNext = PW'((int'(rrPtr) + k + 1) % N);
            end
        end
    end
    // pointer only moves on an actual transfer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rrPtr <= '0;
        else if (advance) rrPtr <= ptrNext;
    end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: register-file write port owner with round-robin writeback and pending scoreboard
module regfile_wb_scheduler #(
    parameter int N_REQ = 2,
    parameter int XLEN  = 64,
    parameter int NREG  = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic                   alloc_valid,
    input  logic [4:0]             alloc_rd,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    output logic                   stall,
    output logic [NREG-1:0]        pending_vec,
    regfile_wb_scheduler_if.slave  wb,
    output logic                   RegWrite,
    output logic [4:0]             writeReg,
    output logic [XLEN-1:0]        writeData_R
);
    import regfile_wb_scheduler_pkg::*;
    logic [N_REQ-1:0] gnt;
    logic xfer;
    creg_addr_t selRd;
    logic [XLEN-1:0] selData;
    logic [NREG-1:0] setMask, clrMask, pendingNext;
    rr_arbiter #(.N(N_REQ)) arb (.clk(clk), .rstn(rstn), .req(wb.wb_valid), .advance(xfer), .gnt(gnt));
    assign wb.wb_ready = gnt;
    assign xfer = |gnt;
    // mux the granted request onto the commit path
    always_comb begin
        selRd = '0;
        selData = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                selRd = wb.wb_rd[i*5 +: 5];
                selData = wb.wb_data[i*XLEN +: XLEN];
            end
        end
    end
    // hazard query and scoreboard update; a new producer beats a same-cycle commit, flush beats both
    always_comb begin
        stall = pending_vec[rs1] | pending_vec[rs2] | pending_vec[alloc_rd];
        setMask = (alloc_valid && !stall && alloc_rd != '0) ? NREG'(1) << alloc_rd : '0;
        clrMask = RegWrite ? NREG'(1) << writeReg : '0;
        pendingNext = flush ? '0 : (((pending_vec & ~clrMask) | setMask) & ~NREG'(1));
    end
    // scoreboard register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pending_vec <= '0;
        else pending_vec <= pendingNext;
    end
    // commit register: one cycle after transfer, x0 writes suppressed
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            RegWrite <= 1'b0;
            writeReg <= '0;
            writeData_R <= '0;
        end else begin
            RegWrite <= xfer && selRd != '0;
            if (xfer) begin
                writeReg <= selRd;
                writeData_R <= selData;
            end
        end
    end
endmodule
